// File: rtl/keccak_pad_pkg.sv
// Shared types and constants for the Keccak SHA-3 padding front-end.
// Latency: n/a (types only).
// Backpressure: n/a.
// state_t is the 5x5 lane state also consumed by the sponge core.
package keccak_pad_pkg;

  typedef logic [63:0] lane_t;

  // lane k = x + 5y lives at [x][y]
  typedef lane_t [0:4][0:4] state_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEND   = 2'd1,
    PADBLK = 2'd2
  } fsm_t;

  localparam logic [7:0] PAD_FINAL          = 8'h80;
  localparam int         DEFAULT_RATE_LANES = 17;
  localparam logic [7:0] DEFAULT_DOMAIN     = 8'h06;

endpackage

// File: rtl/keccak_pad_lane.sv
// Masks one input lane to its valid bytes and ORs in SHA-3 padding bytes.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: word/nbytes = raw lane and valid low-byte count (>=8 means full lane);
//        insert_domain places DOMAIN at byte nbytes when nbytes<8;
//        insert_final ORs PAD_FINAL into byte 7; lane = result.
module keccak_pad_lane
  import keccak_pad_pkg::*;
#(
  parameter logic [7:0] DOMAIN = DEFAULT_DOMAIN
) (
  input  logic [63:0] word,
  input  logic [3:0]  nbytes,
  input  logic        insert_domain,
  input  logic        insert_final,
  output logic [63:0] lane
);

  always_comb begin
    lane = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(nbytes)) begin
        lane[8*b +: 8] = word[8*b +: 8];
      end else if (insert_domain && (b == int'(nbytes))) begin
        lane[8*b +: 8] = DOMAIN;
      end
    end
    // OR rather than overwrite so a domain byte at position 7 becomes 0x86
    if (insert_final) begin
      lane[63:56] = lane[63:56] | PAD_FINAL;
    end
  end

endmodule

// File: rtl/keccak_pad.sv
// SHA-3 padder: packs 64-bit LE message words into rate blocks, pads, emits 5x5 state.
// Latency: block valid the cycle after the accepting edge of its completing word.
// Backpressure: holds blk_data/blk_last until blk_ready; in_ready low outside FILL.
// Ports: clk, rst (sync, active-high); in_data/in_bytes/in_last/in_valid/in_ready
//        message word stream; blk_data/blk_valid/blk_last/blk_ready block stream.
// Optional: define KECCAK_PAD_ERR_EN to add sticky output err and drop illegal words.
module keccak_pad
  import keccak_pad_pkg::*;
#(
  parameter int         WIDTH      = 64,
  parameter int         RATE_LANES = DEFAULT_RATE_LANES,
  parameter logic [7:0] DOMAIN     = DEFAULT_DOMAIN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [3:0]                   in_bytes,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [0:4][0:4][WIDTH-1:0]   blk_data,
  output logic                         blk_valid,
  output logic                         blk_last,
  input  logic                         blk_ready
`ifdef KECCAK_PAD_ERR_EN
  ,
  output logic                         err
`endif
);

  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

  fsm_t       state;
  lane_t      lanes      [RATE_LANES];
  lane_t      fill_lanes [RATE_LANES];
  lane_t      pad_lanes  [RATE_LANES];
  logic [4:0] lane_cnt;
  logic       pad_pending;

  logic       accept;
  logic       drop;
  logic       word_full;
  logic       at_end;
  logic       pad_now;
  lane_t      lane_out;

  assign in_ready  = (state == FILL) && !rst;
  assign accept    = in_valid && in_ready;
  assign word_full = (in_bytes >= 4'd8);
  assign at_end    = (lane_cnt == LAST_LANE);

  // Padding fits in this block unless a full last word fills its final lane;
  // that case needs a separate pad-only block.
  assign pad_now   = in_last && !(word_full && at_end);

`ifdef KECCAK_PAD_ERR_EN
  assign drop = (in_bytes > 4'd8) || (!in_last && (in_bytes < 4'd8));
`else
  assign drop = 1'b0;
`endif

  keccak_pad_lane #(
    .DOMAIN (DOMAIN)
  ) u_lane (
    .word          (in_data),
    .nbytes        (in_bytes),
    .insert_domain (in_last),
    .insert_final  (pad_now && at_end),
    .lane          (lane_out)
  );

  // Buffer contents after accepting the current word.
  always_comb begin
    for (int i = 0; i < RATE_LANES; i++) begin
      fill_lanes[i] = lanes[i];
      if (i == int'(lane_cnt)) begin
        fill_lanes[i] = lane_out;
      end
      // A full last word pushes the domain byte into the following lane.
      if (in_last && word_full && (i == int'(lane_cnt) + 1)) begin
        fill_lanes[i][7:0] = fill_lanes[i][7:0] | DOMAIN;
      end
      // Final bit for a lane other than the one being written (the lane
      // module already handles the case where they coincide).
      if (pad_now && !at_end && (i == RATE_LANES - 1)) begin
        fill_lanes[i][63:56] = fill_lanes[i][63:56] | PAD_FINAL;
      end
    end
  end

  // Pad-only block: domain at lane 0 byte 0, final at last rate lane byte 7.
  always_comb begin
    for (int i = 0; i < RATE_LANES; i++) begin
      pad_lanes[i] = '0;
      if (i == 0) begin
        pad_lanes[i][7:0] = DOMAIN;
      end
      if (i == RATE_LANES - 1) begin
        pad_lanes[i][63:56] = pad_lanes[i][63:56] | PAD_FINAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      lane_cnt    <= '0;
      pad_pending <= 1'b0;
      blk_valid   <= 1'b0;
      blk_last    <= 1'b0;
      for (int i = 0; i < RATE_LANES; i++) begin
        lanes[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (accept && !drop) begin
            lanes <= fill_lanes;
            if (in_last || at_end) begin
              state       <= SEND;
              blk_valid   <= 1'b1;
              blk_last    <= pad_now;
              pad_pending <= in_last && !pad_now;
            end else begin
              lane_cnt <= lane_cnt + 5'd1;
            end
          end
        end
        SEND: begin
          if (blk_ready) begin
            for (int i = 0; i < RATE_LANES; i++) begin
              lanes[i] <= '0;
            end
            lane_cnt  <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            state     <= pad_pending ? PADBLK : FILL;
          end
        end
        PADBLK: begin
          lanes       <= pad_lanes;
          pad_pending <= 1'b0;
          blk_valid   <= 1'b1;
          blk_last    <= 1'b1;
          state       <= SEND;
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef KECCAK_PAD_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && drop) begin
      err <= 1'b1;
    end
  end
`endif

  // Lane k = x + 5y drives blk_data[x][y]; capacity lanes are tied to zero.
  for (genvar k = 0; k < 25; k++) begin : g_map
    if (k < RATE_LANES) begin : g_rate
      assign blk_data[k % 5][k / 5] = lanes[k];
    end else begin : g_cap
      assign blk_data[k % 5][k / 5] = '0;
    end
  end

endmodule

// File: tb/tb_keccak_pad.sv
// Scoreboard bench for keccak_pad: byte-level SHA-3 padding model vs DUT blocks.
// Latency: n/a.
// Backpressure: blk_ready randomised, forced low or held high per phase.
module tb_keccak_pad;

  localparam int RL = 17;
  localparam int RB = RL * 8;

  logic                      clk;
  logic                      rst;
  logic [63:0]               in_data;
  logic [3:0]                in_bytes;
  logic                      in_last;
  logic                      in_valid;
  logic                      in_ready;
  logic [0:4][0:4][63:0]     blk_data;
  logic                      blk_valid;
  logic                      blk_last;
  logic                      blk_ready;
`ifdef KECCAK_PAD_ERR_EN
  logic                      err;
`endif

  typedef struct packed {
    logic [24:0][63:0] lanes;
    logic              last;
  } blk_t;

  blk_t         sb[$];
  byte unsigned cur_msg[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  bit           bp_hold    = 1'b0;
  bit           rdy_always = 1'b0;

  keccak_pad dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
`ifdef KECCAK_PAD_ERR_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: append 0x06, zero-fill to a rate multiple, OR 0x80 into the last byte.
  task automatic model_push();
    byte unsigned p[$];
    int           nblk;
    blk_t         b;
    p = cur_msg;
    p.push_back(8'h06);
    while (p.size() % RB != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / RB;
    for (int i = 0; i < nblk; i++) begin
      b = '0;
      for (int k = 0; k < RL; k++)
        for (int j = 0; j < 8; j++)
          b.lanes[k][8*j +: 8] = p[i*RB + 8*k + j];
      b.last = (i == nblk - 1);
      sb.push_back(b);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the word is accepted.
  task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input logic l);
    int n;
    in_data  = d;
    in_bytes = nb;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input bit split);
    int          len;
    int          pos;
    int          nb;
    logic [63:0] d;
    len = cur_msg.size();
    pos = 0;
    model_push();
    if (len == 0) begin
      send_word(rnd64(), 4'd0, 1'b1);
    end else begin
      while (pos < len) begin
        nb = (len - pos >= 8) ? 8 : len - pos;
        d  = rnd64();
        for (int j = 0; j < nb; j++) d[8*j +: 8] = cur_msg[pos + j];
        send_word(d, 4'(nb), (pos + nb == len) && !split);
        pos += nb;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      if (split) send_word(rnd64(), 4'd0, 1'b1);
    end
  endtask

  task automatic fill_random(input int len);
    cur_msg.delete();
    for (int i = 0; i < len; i++) cur_msg.push_back(8'($urandom));
  endtask

  task automatic run_rand(input int len);
    fill_random(len);
    send_msg((len % 8 == 0) && (len > 0) && ($urandom_range(0, 1) == 1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // blk_ready driver
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_hold)         blk_ready = 1'b0;
      else if (rdy_always) blk_ready = 1'b1;
      else                 blk_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every valid cycle is compared with the scoreboard head; pop on handshake.
  initial begin
    blk_t exp;
    bit   prev_hs;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_hs) check("valid_drop_after_hs", 64'(blk_valid), 64'd0);
      prev_hs = 1'b0;
      if (blk_valid && !rst) begin
        if (sb.size() == 0) begin
          check("unexpected_block", 64'(blk_valid), 64'd0);
        end else begin
          exp = sb[0];
          for (int k = 0; k < 25; k++)
            check($sformatf("lane%0d", k), blk_data[k % 5][k / 5], exp.lanes[k]);
          check("blk_last", 64'(blk_last), 64'(exp.last));
          check("in_ready_in_send", 64'(in_ready), 64'd0);
          if (blk_ready) begin
            void'(sb.pop_front());
            prev_hs = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_bytes = '0;
    in_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_blk_valid", 64'(blk_valid), 64'd0);
    check("rst_blk_last", 64'(blk_last), 64'd0);
    check("rst_lane0", blk_data[0][0], 64'd0);
    check("rst_lane16", blk_data[1][3], 64'd0);
`ifdef KECCAK_PAD_ERR_EN
    check("rst_err", 64'(err), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty message, "abc", 135 and 136 bytes
    cur_msg.delete();
    send_msg(1'b0);
    cur_msg = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    run_rand(135);
    fill_random(136);
    send_msg(1'b0);
    wait_drain();

    // Backpressure: hold blk_ready low for 5 cycles while a block waits
    bp_hold = 1'b1;
    cur_msg = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    n = 0;
    while (!blk_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_rise", 64'(blk_valid), 64'd1);
    repeat (5) @(negedge clk);
    check("bp_valid_held", 64'(blk_valid), 64'd1);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_one_pending", 64'(sb.size()), 64'd1);
    @(posedge clk);
    #1;
    bp_hold = 1'b0;
    wait_drain();

    // Reset after 9 words of an unfinished message
    for (int w = 0; w < 9; w++) send_word(rnd64(), 4'd8, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_blk_valid", 64'(blk_valid), 64'd0);
    check("midrst_blk_last", 64'(blk_last), 64'd0);
    check("midrst_lane0", blk_data[0][0], 64'd0);
    check("midrst_lane8", blk_data[3][1], 64'd0);
    @(posedge clk);
    #1;
    rdy_always = 1'b1;
    cur_msg = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    wait_drain();
    rdy_always = 1'b0;

`ifdef KECCAK_PAD_ERR_EN
    // Illegal short non-last word is dropped and flags err
    send_word(rnd64(), 4'd5, 1'b0);
    @(negedge clk);
    check("err_set", 64'(err), 64'd1);
    @(posedge clk);
    #1;
    cur_msg = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    wait_drain();
`endif

    // Random traffic, including the two-block boundary lengths
    run_rand(271);
    run_rand(272);
    for (int m = 0; m < 12; m++) run_rand($urandom_range(0, 300));
    wait_drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
